// File: rtl/ubx_pkg.sv
// Shared UBX constants, sequencer state encoding and the Fletcher-8 step.
package ubx_pkg;

  localparam logic [7:0] UBX_SYNC1     = 8'hB5;
  localparam logic [7:0] UBX_SYNC2     = 8'h62;
  localparam logic [7:0] UBX_CLASS_CFG = 8'h06;
  localparam logic [7:0] UBX_CLASS_ACK = 8'h05;

  typedef enum logic [3:0] {
    IDLE, SYNC1, SYNC2, CLASS, ID, LEN_L, LEN_H, PAYLOAD,
    CKA, CKB, WAIT_ACK, GAP, FINISH
  } state_t;

  typedef struct packed {
    logic [7:0] ck_b;
    logic [7:0] ck_a;
  } fletcher_t;

  // One Fletcher-8 step: CK_A accumulates bytes, CK_B accumulates the new CK_A.
  function automatic fletcher_t fletcher_update(input fletcher_t ck, input logic [7:0] data);
    fletcher_t r;
    r.ck_a = ck.ck_a + data;
    r.ck_b = ck.ck_b + r.ck_a;
    return r;
  endfunction

endpackage

// File: rtl/ubx_cfg_table.sv
// Boot-time configuration message table: class, id, length and payload bytes.
module ubx_cfg_table
  import ubx_pkg::*;
#(
  parameter int IDX_W  = 2,
  parameter int BYTE_W = 7
) (
  input  logic [IDX_W-1:0]  msg_idx,
  input  logic [BYTE_W-1:0] byte_idx,
  output logic [7:0]        msg_class,
  output logic [7:0]        msg_id,
  output logic [15:0]       msg_len,
  output logic [7:0]        payload_byte
);

  // Pure lookup; payload bytes beyond the listed ones read as zero.
  always_comb begin
    msg_class    = UBX_CLASS_CFG;
    msg_id       = 8'h00;
    msg_len      = 16'd0;
    payload_byte = 8'h00;
    case (32'(msg_idx))
      0: begin
        msg_id  = 8'h24;
        msg_len = 16'd36;
        case (32'(byte_idx))
          0:       payload_byte = 8'h01;
          2:       payload_byte = 8'h07;
          default: payload_byte = 8'h00;
        endcase
      end
      1: begin
        msg_id  = 8'h01;
        msg_len = 16'd3;
        case (32'(byte_idx))
          0:       payload_byte = 8'h01;
          1:       payload_byte = 8'h02;
          2:       payload_byte = 8'h01;
          default: payload_byte = 8'h00;
        endcase
      end
      2: begin
        msg_id  = 8'h01;
        msg_len = 16'd3;
        case (32'(byte_idx))
          0:       payload_byte = 8'h01;
          1:       payload_byte = 8'h12;
          2:       payload_byte = 8'h01;
          default: payload_byte = 8'h00;
        endcase
      end
      default: begin
        msg_len = 16'd0;
      end
    endcase
  end

endmodule

// File: rtl/ubx_cfg_sequencer.sv
// Streams the UBX configuration table to the UART TX, framing each message
// with sync bytes and an on-the-fly Fletcher-8 checksum, with optional ACK
// wait, timeout and retry.
module ubx_cfg_sequencer
  import ubx_pkg::*;
#(
  parameter int NUM_MSG     = 3,
  parameter int MAX_PAYLOAD = 64,
  parameter int ACK_EN      = 1,
  parameter int ACK_TIMEOUT = 1000000,
  parameter int MAX_RETRY   = 2,
  parameter int GAP_CYCLES  = 16,
  localparam int IDX_W      = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] cur_msg,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             ack_valid,
  input  logic             ack_nak
);

  localparam int BYTE_W = $clog2(MAX_PAYLOAD + 1);
  localparam int TMR_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int RTY_W  = $clog2(MAX_RETRY + 2);
  localparam logic [IDX_W-1:0] LAST_MSG = IDX_W'(NUM_MSG - 1);

  state_t            state;
  fletcher_t         ck;
  fletcher_t         ck_next;
  logic [BYTE_W-1:0] byte_cnt;
  logic [TMR_W-1:0]  timer;
  logic [GAP_W-1:0]  gap_cnt;
  logic [RTY_W-1:0]  retry_cnt;
  logic              last_done;
  logic              accept;
  logic [7:0]        msg_class;
  logic [7:0]        msg_id;
  logic [15:0]       msg_len;
  logic [7:0]        payload_byte;

  ubx_cfg_table #(
    .IDX_W  (IDX_W),
    .BYTE_W (BYTE_W)
  ) u_table (
    .msg_idx      (cur_msg),
    .byte_idx     (byte_cnt),
    .msg_class    (msg_class),
    .msg_id       (msg_id),
    .msg_len      (msg_len),
    .payload_byte (payload_byte)
  );

  assign accept  = tx_valid && tx_ready;
  assign ck_next = fletcher_update(ck, tx_data);

  // Sequencer FSM; every output is registered, next byte is loaded on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cur_msg   <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      ck        <= '0;
      byte_cnt  <= '0;
      timer     <= '0;
      gap_cnt   <= '0;
      retry_cnt <= '0;
      last_done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= SYNC1;
            busy      <= 1'b1;
            error     <= 1'b0;
            cur_msg   <= '0;
            retry_cnt <= '0;
            last_done <= 1'b0;
            byte_cnt  <= '0;
            ck        <= '0;
            tx_valid  <= 1'b1;
            tx_data   <= UBX_SYNC1;
          end
        end
        SYNC1: if (accept) begin
          state   <= SYNC2;
          tx_data <= UBX_SYNC2;
        end
        SYNC2: if (accept) begin
          state   <= CLASS;
          tx_data <= msg_class;
        end
        CLASS: if (accept) begin
          ck      <= ck_next;
          state   <= ID;
          tx_data <= msg_id;
        end
        ID: if (accept) begin
          ck      <= ck_next;
          state   <= LEN_L;
          tx_data <= msg_len[7:0];
        end
        LEN_L: if (accept) begin
          ck      <= ck_next;
          state   <= LEN_H;
          tx_data <= msg_len[15:8];
        end
        LEN_H: if (accept) begin
          ck <= ck_next;
          if (msg_len == 16'd0) begin
            state   <= CKA;
            tx_data <= ck_next.ck_a;
          end else begin
            state    <= PAYLOAD;
            tx_data  <= payload_byte;
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        PAYLOAD: if (accept) begin
          ck <= ck_next;
          // byte_cnt already points one past the byte being accepted
          if (16'(byte_cnt) == msg_len) begin
            state   <= CKA;
            tx_data <= ck_next.ck_a;
          end else begin
            tx_data  <= payload_byte;
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        CKA: if (accept) begin
          state   <= CKB;
          tx_data <= ck.ck_b;
        end
        CKB: if (accept) begin
          tx_valid <= 1'b0;
          timer    <= '0;
          gap_cnt  <= '0;
          state    <= (ACK_EN != 0) ? WAIT_ACK : GAP;
        end
        WAIT_ACK: begin
          // ack_valid wins over a timeout landing in the same cycle
          if (ack_valid && !ack_nak) begin
            state     <= GAP;
            gap_cnt   <= '0;
            retry_cnt <= '0;
            if (cur_msg == LAST_MSG) last_done <= 1'b1;
            else                     cur_msg   <= cur_msg + 1'b1;
          end else if (ack_valid || timer == TMR_W'(ACK_TIMEOUT - 1)) begin
            if (retry_cnt >= RTY_W'(MAX_RETRY)) begin
              error <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              gap_cnt   <= '0;
              state     <= GAP;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            if ((ACK_EN == 0) ? (cur_msg == LAST_MSG) : last_done) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              if (ACK_EN == 0) begin
                cur_msg   <= cur_msg + 1'b1;
                retry_cnt <= '0;
              end
              state    <= SYNC1;
              tx_valid <= 1'b1;
              tx_data  <= UBX_SYNC1;
              ck       <= '0;
              byte_cnt <= '0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ubx_cfg_sequencer.sv
// Bench for ubx_cfg_sequencer: one instance without ACK wait, one with a
// short ACK timeout; byte scoreboards fed at start, drained by collectors.
module tb_ubx_cfg_sequencer;

  localparam int GAP = 16;
  localparam int TMO = 100;

  logic       clk;
  logic       rst_n_a, start_a, tx_ready_a, ack_valid_a, ack_nak_a;
  logic       busy_a, done_a, error_a, tx_valid_a;
  logic [1:0] cur_msg_a;
  logic [7:0] tx_data_a;
  logic       rst_n_b, start_b, tx_ready_b, ack_valid_b, ack_nak_b;
  logic       busy_b, done_b, error_b, tx_valid_b;
  logic [1:0] cur_msg_b;
  logic [7:0] tx_data_b;

  ubx_cfg_sequencer #(.ACK_EN(0), .GAP_CYCLES(GAP)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .busy(busy_a), .done(done_a),
    .error(error_a), .cur_msg(cur_msg_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .ack_valid(ack_valid_a), .ack_nak(ack_nak_a)
  );

  ubx_cfg_sequencer #(.ACK_EN(1), .ACK_TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .busy(busy_b), .done(done_b),
    .error(error_b), .cur_msg(cur_msg_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .ack_valid(ack_valid_b), .ack_nak(ack_nak_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nchk = 0;
  int nfail = 0;

  logic [7:0] frm [3][48];
  int         frm_len [3];
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];

  int   pos_a, pos_b, frames_a, frames_b, dcount_a, dcount_b;
  bit   stall_mode;

  typedef struct {
    int delay;     // cycles from checksum acceptance to the ack pulse
    bit send;      // 0: let it time out
    bit nak;
    int exp_cur;   // cur_msg expected while waiting
    bit gap_chk;   // measure the idle gap before the next frame
    bit mid_ack;   // stray ack pulse during the frame
  } resp_t;
  resp_t vec [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic build_frames();
    logic [7:0] ids [3];
    int         lens [3];
    logic [7:0] pl [3][3];
    logic [7:0] cka [3];
    logic [7:0] ckb [3];
    ids[0] = 8'h24; ids[1] = 8'h01; ids[2] = 8'h01;
    lens[0] = 36; lens[1] = 3; lens[2] = 3;
    pl[0][0] = 8'h01; pl[0][1] = 8'h00; pl[0][2] = 8'h07;
    pl[1][0] = 8'h01; pl[1][1] = 8'h02; pl[1][2] = 8'h01;
    pl[2][0] = 8'h01; pl[2][1] = 8'h12; pl[2][2] = 8'h01;
    cka[0] = 8'h56; ckb[0] = 8'hD6;
    cka[1] = 8'h0E; ckb[1] = 8'h47;
    cka[2] = 8'h1E; ckb[2] = 8'h67;
    for (int m = 0; m < 3; m++) begin
      frm[m][0] = 8'hB5; frm[m][1] = 8'h62; frm[m][2] = 8'h06; frm[m][3] = ids[m];
      frm[m][4] = 8'(lens[m]); frm[m][5] = 8'h00;
      for (int i = 0; i < lens[m]; i++) frm[m][6+i] = (i < 3) ? pl[m][i] : 8'h00;
      frm[m][6+lens[m]] = cka[m];
      frm[m][7+lens[m]] = ckb[m];
      frm_len[m] = lens[m] + 8;
    end
  endtask

  task automatic push_frame(input bit sel, input int m);
    for (int i = 0; i < frm_len[m]; i++) begin
      if (sel) q_b.push_back(frm[m][i]);
      else     q_a.push_back(frm[m][i]);
    end
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int limit, output int cyc);
    bit got = 0;
    cyc = 0;
    while (cyc < limit && !got) begin
      @(posedge clk); #1;
      cyc++;
      got = sel ? done_b : done_a;
    end
    if (!got) begin
      nchk++; nfail++;
      $display("FAIL %s_done_timeout: got no done after %0d cycles", sel ? "b" : "a", cyc);
    end
  endtask

  task automatic chk_reset_vals(input bit sel);
    chk(sel ? "b_rst_busy" : "a_rst_busy", sel ? busy_b : busy_a, 0);
    chk(sel ? "b_rst_done" : "a_rst_done", sel ? done_b : done_a, 0);
    chk(sel ? "b_rst_error" : "a_rst_error", sel ? error_b : error_a, 0);
    chk(sel ? "b_rst_cur_msg" : "a_rst_cur_msg", sel ? cur_msg_b : cur_msg_a, 0);
    chk(sel ? "b_rst_tx_valid" : "a_rst_tx_valid", sel ? tx_valid_b : tx_valid_a, 0);
    chk(sel ? "b_rst_tx_data" : "a_rst_tx_data", sel ? tx_data_b : tx_data_a, 0);
  endtask

  // Wait for the end of the next frame on dut_b, then answer as the entry says.
  task automatic run_entry(input int i);
    int prev = frames_b;
    bit got = 0;
    int n;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge clk); #1;
      ack_valid_b = vec[i].mid_ack && (k == 8);
      if (frames_b != prev) got = 1;
    end
    ack_valid_b = 1'b0;
    if (!got) begin
      nchk++; nfail++;
      $display("FAIL b_frame_timeout: entry %0d got no frame end, required one", i);
      return;
    end
    chk("b_cur_msg", cur_msg_b, vec[i].exp_cur);
    if (vec[i].send) begin
      repeat (vec[i].delay - 1) @(posedge clk);
      #1;
      ack_valid_b = 1'b1;
      ack_nak_b   = vec[i].nak;
      @(posedge clk); #1;
      ack_valid_b = 1'b0;
      ack_nak_b   = 1'b0;
      if (vec[i].gap_chk) begin
        n = 0;
        while (n < 200) begin
          @(posedge clk); #1;
          n++;
          if (tx_valid_b) break;
        end
        chk("b_gap_len", n, GAP);
      end
    end
  endtask

  // Ready driver for dut_a: always ready, or random stalls.
  initial begin
    tx_ready_a = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready_a = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Collector for dut_a: scoreboard pop, frame tracking and stall stability.
  initial begin
    logic [15:0] len;
    logic [7:0]  held;
    bit          stall;
    pos_a = 0; frames_a = 0; stall = 0; len = 0; held = 0;
    forever begin
      @(negedge clk);
      if (!rst_n_a) begin
        pos_a = 0;
        stall = 0;
      end else begin
        if (stall) begin
          chk("a_stall_valid", tx_valid_a, 1);
          chk("a_stall_data", tx_data_a, held);
        end
        stall = tx_valid_a && !tx_ready_a;
        held  = tx_data_a;
        if (tx_valid_a && tx_ready_a) begin
          if (q_a.size() == 0) begin
            nchk++; nfail++;
            $display("FAIL a_extra_byte: got %02h, required no byte", tx_data_a);
          end else begin
            chk("a_byte", tx_data_a, q_a.pop_front());
          end
          if (pos_a == 4) len[7:0]  = tx_data_a;
          if (pos_a == 5) len[15:8] = tx_data_a;
          pos_a++;
          if (pos_a >= 6 && pos_a == 8 + int'(len)) begin
            frames_a++;
            pos_a = 0;
          end
        end
      end
    end
  end

  // Collector for dut_b.
  initial begin
    logic [15:0] len;
    pos_b = 0; frames_b = 0; len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n_b) begin
        pos_b = 0;
      end else if (tx_valid_b && tx_ready_b) begin
        if (q_b.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL b_extra_byte: got %02h, required no byte", tx_data_b);
        end else begin
          chk("b_byte", tx_data_b, q_b.pop_front());
        end
        if (pos_b == 4) len[7:0]  = tx_data_b;
        if (pos_b == 5) len[15:8] = tx_data_b;
        pos_b++;
        if (pos_b >= 6 && pos_b == 8 + int'(len)) begin
          frames_b++;
          pos_b = 0;
        end
      end
    end
  end

  // done pulses are counted; busy must already be low while done is high.
  initial begin
    dcount_a = 0;
    dcount_b = 0;
    forever begin
      @(negedge clk);
      if (done_a) begin
        dcount_a++;
        chk("a_busy_at_done", busy_a, 0);
      end
      if (done_b) begin
        dcount_b++;
        chk("b_busy_at_done", busy_b, 0);
      end
    end
  end

  initial begin
    #500000;
    nfail++;
    $display("FAIL watchdog: got simulation still running, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int exp_cyc;
    int fr;
    // delay, send, nak, exp_cur, gap_chk, mid_ack
    vec[0] = '{5,   1, 0, 0, 1, 0};  // msg0 ACK
    vec[1] = '{3,   1, 1, 1, 1, 0};  // msg1 NAK -> resend
    vec[2] = '{7,   1, 0, 1, 1, 0};  // msg1 ACK
    vec[3] = '{2,   1, 0, 2, 0, 0};  // msg2 ACK
    vec[4] = '{0,   0, 0, 0, 0, 0};  // msg0 timeout
    vec[5] = '{0,   0, 0, 0, 0, 0};  // msg0 timeout
    vec[6] = '{0,   0, 0, 0, 0, 0};  // msg0 timeout -> error
    vec[7] = '{TMO, 1, 0, 0, 1, 1};  // ACK on the timeout cycle, stray ack mid-frame
    vec[8] = '{4,   1, 0, 1, 1, 0};
    vec[9] = '{TMO, 1, 0, 2, 0, 0};

    build_frames();
    stall_mode = 0;
    rst_n_a = 0; rst_n_b = 0;
    start_a = 0; start_b = 0;
    ack_valid_a = 0; ack_nak_a = 0;
    ack_valid_b = 0; ack_nak_b = 0;
    tx_ready_b = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals(0);
    chk_reset_vals(1);
    @(negedge clk);
    rst_n_a = 1; rst_n_b = 1;
    @(posedge clk); #1;

    // No ACK wait, ready high: full sequence at one byte per cycle; a start
    // pulse in the middle must be ignored.
    for (int m = 0; m < 3; m++) push_frame(0, m);
    pulse_start(0);
    chk("a_busy_after_start", busy_a, 1);
    repeat (19) @(posedge clk);
    #1;
    pulse_start(0);
    wait_done(0, 400, c);
    exp_cyc = 0;
    for (int m = 0; m < 3; m++) exp_cyc += frm_len[m] + GAP;
    chk("a_seq_cycles", 20 + c, exp_cyc);
    chk("a_error_ok", error_a, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("a_done_count", dcount_a, 1);
    chk("a_queue_empty", q_a.size(), 0);
    chk("a_busy_idle", busy_a, 0);

    // Random ready stalls: same byte stream, data held across stalls.
    stall_mode = 1;
    for (int m = 0; m < 3; m++) push_frame(0, m);
    pulse_start(0);
    wait_done(0, 2000, c);
    stall_mode = 0;
    chk("a_stall_error", error_a, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("a_stall_queue_empty", q_a.size(), 0);
    chk("a_stall_done_count", dcount_a, 2);

    // Reset in the middle of message 0 payload, then a clean rerun.
    for (int m = 0; m < 3; m++) push_frame(0, m);
    pulse_start(0);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (pos_a >= 10) break;
    end
    #2;
    chk("a_valid_before_rst", tx_valid_a, 1);
    rst_n_a = 0;
    #1;
    chk("a_async_drop", tx_valid_a, 0);
    q_a.delete();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals(0);
    @(negedge clk);
    rst_n_a = 1;
    @(posedge clk); #1;
    for (int m = 0; m < 3; m++) push_frame(0, m);
    pulse_start(0);
    wait_done(0, 400, c);
    chk("a_rerun_error", error_a, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("a_rerun_queue_empty", q_a.size(), 0);

    // ACK mode: NAK message 1 once, then ACK everything.
    push_frame(1, 0); push_frame(1, 1); push_frame(1, 1); push_frame(1, 2);
    pulse_start(1);
    for (int i = 0; i < 4; i++) run_entry(i);
    wait_done(1, 200, c);
    chk("b_final_gap", c, GAP);
    chk("b_nak_error", error_b, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("b_nak_queue_empty", q_b.size(), 0);
    chk("b_nak_done_count", dcount_b, 1);

    // Never acknowledge message 0: three attempts, then error.
    push_frame(1, 0); push_frame(1, 0); push_frame(1, 0);
    fr = frames_b;
    pulse_start(1);
    for (int i = 4; i < 7; i++) run_entry(i);
    wait_done(1, 300, c);
    chk("b_timeout_cycles", c, TMO);
    chk("b_error_set", error_b, 1);
    repeat (60) @(posedge clk);
    #1;
    chk("b_only_three_frames", frames_b - fr, 3);
    chk("b_timeout_queue_empty", q_b.size(), 0);
    chk("b_error_sticky", error_b, 1);
    chk("b_timeout_done_count", dcount_b, 2);

    // ACK on the timeout cycle counts as ACK; stray ack mid-frame ignored.
    for (int m = 0; m < 3; m++) push_frame(1, m);
    pulse_start(1);
    chk("b_error_cleared", error_b, 0);
    for (int i = 7; i < 10; i++) run_entry(i);
    wait_done(1, 200, c);
    chk("b_coinc_error", error_b, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("b_coinc_queue_empty", q_b.size(), 0);
    chk("b_coinc_done_count", dcount_b, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
